// File: rtl/multicycle_control.sv
// ============================================================================
// Module   : multicycle_control
// Purpose  : Multicycle MIPS control FSM (fetch/decode/execute/memory/write-back)
//            with mem_ready handshake, ADDI, illegal-opcode flag and retire pulse.
//            Optional J instruction enabled by defining MC_JUMP_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_control #(
    parameter int ALUOP_W  = 2,
    parameter int OPCODE_W = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] Opcode,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                MemtoReg,
    output logic                RegDst,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic [1:0]          PCSource,
    output logic                illegal,
    output logic                retire
);

    localparam logic [OPCODE_W-1:0] c_OP_RTYPE = OPCODE_W'(6'b000000);
    localparam logic [OPCODE_W-1:0] c_OP_LW    = OPCODE_W'(6'b100011);
    localparam logic [OPCODE_W-1:0] c_OP_SW    = OPCODE_W'(6'b101011);
    localparam logic [OPCODE_W-1:0] c_OP_BEQ   = OPCODE_W'(6'b000100);
    localparam logic [OPCODE_W-1:0] c_OP_ADDI  = OPCODE_W'(6'b001000);
`ifdef MC_JUMP_EN
    localparam logic [OPCODE_W-1:0] c_OP_J     = OPCODE_W'(6'b000010);
`endif

    localparam logic [ALUOP_W-1:0] c_ALUOP_ADD = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] c_ALUOP_SUB = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] c_ALUOP_R   = ALUOP_W'(2);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
`ifdef MC_JUMP_EN
        S_JUMP   = 4'd11,
`endif
        S_ADDIWB = 4'd10
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   r_is_lw;

    // Opcode is only valid in DECODE, so the LW/SW choice is remembered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_is_lw <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_is_lw <= (Opcode == c_OP_LW);
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'd0;
        ALUOp       = c_ALUOP_ADD;
        PCSource    = 2'd0;
        illegal     = 1'b0;
        retire      = 1'b0;

        case (r_state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'd1;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = 2'd3;
                if (Opcode == c_OP_RTYPE)                        w_next = S_EXEC;
                else if (Opcode == c_OP_LW || Opcode == c_OP_SW) w_next = S_MEMADR;
                else if (Opcode == c_OP_BEQ)                     w_next = S_BRANCH;
                else if (Opcode == c_OP_ADDI)                    w_next = S_ADDIEX;
`ifdef MC_JUMP_EN
                else if (Opcode == c_OP_J)                       w_next = S_JUMP;
`endif
                else begin
                    illegal = 1'b1;
                    w_next  = S_FETCH;
                end
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'd2;
                w_next  = r_is_lw ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                retire   = 1'b1;
                w_next   = S_FETCH;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                retire   = mem_ready;
                if (mem_ready) w_next = S_FETCH;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = c_ALUOP_R;
                w_next  = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                retire   = 1'b1;
                w_next   = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = c_ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = 2'd1;
                retire      = 1'b1;
                w_next      = S_FETCH;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'd2;
                w_next  = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
                w_next   = S_FETCH;
            end
`ifdef MC_JUMP_EN
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'd2;
                retire   = 1'b1;
                w_next   = S_FETCH;
            end
`endif
            default: begin
                w_next = S_FETCH;
            end
        endcase

        // Reset blanks every output immediately, independent of the state register.
        if (reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            MemtoReg    = 1'b0;
            RegDst      = 1'b0;
            RegWrite    = 1'b0;
            ALUSrcA     = 1'b0;
            ALUSrcB     = 2'd0;
            ALUOp       = '0;
            PCSource    = 2'd0;
            illegal     = 1'b0;
            retire      = 1'b0;
        end
    end

endmodule

`default_nettype wire
